// File: rtl/zaxxon_sound_ppi_if.sv
// rtl/zaxxon_sound_ppi_if.sv - CPU bus bundle for the Zaxxon sound port block
//
// Signals:
//   cpu_cs    chip select
//   cpu_wr    write strobe (level, qualified by cpu_cs)
//   cpu_rd    read strobe (level, qualified by cpu_cs)
//   cpu_addr  register select: 0=PORTA 1=PORTB 2=PORTC 3=CTRL
//   cpu_din   write data
//   cpu_dout  registered read data
// Modports: master drives the bus (CPU side), slave is the port block.

interface zaxxon_sound_ppi_if;
    logic       cpu_cs;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;

    modport master (
        output cpu_cs,
        output cpu_wr,
        output cpu_rd,
        output cpu_addr,
        output cpu_din,
        input  cpu_dout
    );

    modport slave (
        input  cpu_cs,
        input  cpu_wr,
        input  cpu_rd,
        input  cpu_addr,
        input  cpu_din,
        output cpu_dout
    );
endinterface

// File: rtl/zaxxon_sound_ppi.sv
// rtl/zaxxon_sound_ppi.sv - 8255-style sound port block with PORTB one-shot triggers
//
// Parameters:
//   HOLD_CYCLES  one-shot pulse length in clk_sys cycles (1..65535)
// Ports:
//   clk_sys     system clock
//   reset       synchronous active-high reset
//   cpu         CPU bus (zaxxon_sound_ppi_if.slave)
//   trig        PORTA level triggers
//   trig_pulse  one-shot triggers armed by 0->1 edges written to PORTB
//   portc_out   PORTC latch (volume/enable lines)
// Build option:
//   ZAXXON_SND_READBACK_EN  when defined, reads return port contents;
//                           otherwise every read returns 8'hFF.

module zaxxon_sound_ppi #(
    parameter int unsigned HOLD_CYCLES = 48000
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    zaxxon_sound_ppi_if.slave       cpu,
    output logic [7:0]              trig,
    output logic [7:0]              trig_pulse,
    output logic [7:0]              portc_out
);

    localparam logic [15:0] HOLD = 16'(HOLD_CYCLES);

    logic [7:0]  porta;
    logic [7:0]  portb;
    logic [7:0]  portc;
    logic        wr_prev;
    logic [15:0] cnt [8];

    logic        wr_strobe;
    logic        wr_evt;
    logic        a_we;
    logic        b_we;
    logic        c_we;
    logic        ctrl_mode;
    logic        ctrl_bsr;
    logic [7:0]  arm;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [7:0]  dout_q;

    // A held strobe only writes once: the event is the rising edge of cs&wr.
    // wr_prev is cleared by reset so a strobe held across release writes again.
    assign wr_strobe = cpu.cpu_cs & cpu.cpu_wr;
    assign wr_evt    = wr_strobe & ~wr_prev;
    assign rd_en     = cpu.cpu_cs & cpu.cpu_rd;

    always_comb begin
        a_we      = 1'b0;
        b_we      = 1'b0;
        c_we      = 1'b0;
        ctrl_mode = 1'b0;
        ctrl_bsr  = 1'b0;
        if (wr_evt) begin
            case (cpu.cpu_addr)
                2'd0:    a_we = 1'b1;
                2'd1:    b_we = 1'b1;
                2'd2:    c_we = 1'b1;
                default: begin
                    ctrl_mode = cpu.cpu_din[7];
                    ctrl_bsr  = ~cpu.cpu_din[7];
                end
            endcase
        end
    end

    // Only bits rising relative to the previous PORTB latch arm a one-shot;
    // falling bits leave running pulses alone.
    assign arm = b_we ? (cpu.cpu_din & ~portb) : 8'h00;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            porta   <= 8'h00;
            portb   <= 8'h00;
            portc   <= 8'h00;
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_strobe;
            if (ctrl_mode) begin
                porta <= 8'h00;
                portb <= 8'h00;
                portc <= 8'h00;
            end else begin
                if (a_we)     porta <= cpu.cpu_din;
                if (b_we)     portb <= cpu.cpu_din;
                if (c_we)     portc <= cpu.cpu_din;
                if (ctrl_bsr) portc[cpu.cpu_din[3:1]] <= cpu.cpu_din[0];
            end
        end
    end

    // Per-bit down-counters; the pulse is high while the counter is nonzero.
    // Arming takes priority over the decrement, so a re-arm on the expiry
    // cycle reloads instead of letting the pulse drop.
    always_ff @(posedge clk_sys) begin
        for (int n = 0; n < 8; n++) begin
            if (reset || ctrl_mode) begin
                cnt[n] <= 16'd0;
            end else if (arm[n]) begin
                cnt[n] <= HOLD;
            end else if (cnt[n] != 16'd0) begin
                cnt[n] <= cnt[n] - 16'd1;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            trig_pulse[n] = (cnt[n] != 16'd0);
        end
    end

    assign trig      = porta;
    assign portc_out = portc;

    // Read data is sampled from the registers before any same-cycle write
    // lands, so a combined read/write returns the old contents.
`ifdef ZAXXON_SND_READBACK_EN
    always_comb begin
        rd_data = 8'h00;
        case (cpu.cpu_addr)
            2'd0:    rd_data = porta;
            2'd1:    rd_data = portb;
            2'd2:    rd_data = portc;
            default: rd_data = {7'b0, |trig_pulse};
        endcase
    end
`else
    assign rd_data = 8'hFF;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dout_q <= 8'h00;
        end else if (rd_en) begin
            dout_q <= rd_data;
        end
    end

    assign cpu.cpu_dout = dout_q;

endmodule

// File: doc/zaxxon_sound_ppi.md
ZAXXON_SOUND_PPI -- requirements
Module: zaxxon_sound_ppi

Interface
REQ-001 Parameter HOLD_CYCLES, default 48000: one-shot pulse length in clk_sys cycles (1 ms at 48 MHz); legal range 1..65535.
REQ-002 clk_sys  input  1  system clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_cs  input  1  chip select for the sound port block.
REQ-005 cpu_wr  input  1  write strobe, level, qualified by cpu_cs.
REQ-006 cpu_rd  input  1  read strobe, level, qualified by cpu_cs.
REQ-007 cpu_addr  input  2  register select: 0=PORTA, 1=PORTB, 2=PORTC, 3=CTRL.
REQ-008 cpu_din  input  8  write data.
REQ-009 cpu_dout  output  8  registered read data.
REQ-010 trig  output  8  PORTA level triggers, fed to the discrete sound generator.
REQ-011 trig_pulse  output  8  one-shot triggers derived from PORTB.
REQ-012 portc_out  output  8  PORTC latch, volume/enable lines.

Function
REQ-013 Write event SHALL occur only on the first cycle in which (cpu_cs & cpu_wr) is high after a cycle in which it was low; a held strobe produces one write.
REQ-014 PORTA write SHALL latch cpu_din; trig SHALL show the new value on the cycle after the write event (1-cycle latency).
REQ-015 PORTB write SHALL latch cpu_din; each bit transitioning 0->1 versus the previous PORTB latch SHALL arm that bit's one-shot.
REQ-016 Armed bit n: trig_pulse[n] SHALL go high the cycle after the write event and remain high for exactly HOLD_CYCLES cycles, using a 16-bit down-counter per bit.
REQ-017 Re-arm while active (bit written 0 then 1 again) SHALL reload the counter to HOLD_CYCLES; pulse stays high without a gap.
REQ-018 Same-cycle counter expiry and re-arm SHALL resolve in favour of re-arm.
REQ-019 PORTB bit transitioning 1->0 SHALL NOT cut short an active pulse.
REQ-020 PORTC write SHALL latch cpu_din onto portc_out with 1-cycle latency.
REQ-021 CTRL write with cpu_din[7]=1 (mode word) SHALL clear PORTA, PORTB, PORTC and all one-shot counters; trig, trig_pulse and portc_out SHALL be 0 the following cycle.
REQ-022 CTRL write with cpu_din[7]=0 (bit set/reset) SHALL set PORTC bit cpu_din[3:1] to cpu_din[0]; other PORTC bits unchanged.
REQ-023 Read: when cpu_cs & cpu_rd, cpu_dout SHALL update on the next cycle per Configuration; otherwise cpu_dout holds its last value.
REQ-024 Simultaneous cpu_wr and cpu_rd SHALL perform the write; the read returns the pre-write value.

Reset
REQ-025 On reset high at a clk_sys edge: PORTA, PORTB, PORTC, all counters, trig, trig_pulse, portc_out and cpu_dout SHALL be 0, and the write-strobe history SHALL be cleared so that a strobe held through reset release counts as a new write.
REQ-026 Reset asserted mid-pulse SHALL terminate the pulse the following cycle; no pulse resumes after release.

Configuration
REQ-027 Macro ZAXXON_SND_READBACK_EN defined: reads return PORTA, PORTB or PORTC by address, and address 3 returns {7'b0, |trig_pulse}.
REQ-028 Macro ZAXXON_SND_READBACK_EN undefined: all reads return 8'hFF; write behaviour is identical.

Verification
REQ-029 Reset, write PORTA=8'h5A -> trig=8'h5A exactly one cycle after the write event; trig_pulse=0.
REQ-030 HOLD_CYCLES=10, write PORTB=8'h01 -> trig_pulse[0] high for exactly 10 cycles; a held cpu_wr over 5 cycles yields one pulse.
REQ-031 HOLD_CYCLES=10, PORTB=8'h01, then 8'h00 and 8'h01 at cycle 6 -> trig_pulse[0] continuous high until 10 cycles after the second arm.
REQ-032 PORTC=8'h00, CTRL=8'h07 then CTRL=8'h02 -> portc_out=8'h08 then 8'h08 with bit1 cleared (8'h08); CTRL=8'h80 -> all outputs 0.
REQ-033 Reset pulse at cycle 4 of an active 10-cycle pulse -> trig_pulse=0 the next cycle and stays 0.
REQ-034 Read addr 0 after PORTA=8'h3C -> cpu_dout=8'h3C with READBACK_EN, 8'hFF without.
